// File: rtl/pipeline_issue.sv
// Head-of-line issue controller: round-robin selects one eligible ingress buffer per cycle,
// feeds route compute, and tracks each port through pending, backoff and granted states.
module pipeline_issue #(
    parameter int unsigned NUM_BUFFERS  = 5,
    parameter int unsigned RETRY_DELAY  = 4,
    parameter int unsigned META_WIDTH   = 8,
    parameter int unsigned DEST_WIDTH   = 4,
    parameter int unsigned INGRESS_SIZE = $clog2(NUM_BUFFERS) + (NUM_BUFFERS == 1)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic [NUM_BUFFERS-1:0]                  buf_head_valid_i,
    input  logic [NUM_BUFFERS-1:0][META_WIDTH-1:0]  buf_metadata_i,
    input  logic [NUM_BUFFERS-1:0][DEST_WIDTH-1:0]  buf_dest_i,
    input  logic [NUM_BUFFERS-1:0]                  buf_tail_sent_i,
    input  logic                                    pipe_valid_i,
    input  logic [INGRESS_SIZE-1:0]                 pipe_ingress_port_i,
    input  logic                                    pipe_failed_i,
    output logic                                    rc_valid_o,
    output logic [META_WIDTH-1:0]                   rc_metadata_o,
    output logic [DEST_WIDTH-1:0]                   rc_dest_o,
    output logic [INGRESS_SIZE-1:0]                 rc_ingress_port_o,
    output logic [NUM_BUFFERS-1:0]                  granted_o,
    output logic                                    proto_err_o
);

    localparam int unsigned CntW = (RETRY_DELAY > 0) ? $clog2(RETRY_DELAY + 1) : 1;

    typedef enum logic [1:0] {StIdle, StPending, StWait, StGranted} port_state_e;

    port_state_e              state_q [NUM_BUFFERS];
    port_state_e              state_d [NUM_BUFFERS];
    logic [CntW-1:0]          cnt_q   [NUM_BUFFERS];
    logic [CntW-1:0]          cnt_d   [NUM_BUFFERS];
    logic [INGRESS_SIZE-1:0]  rr_ptr_q, rr_ptr_d;
    logic                     rc_valid_q;
    logic [META_WIDTH-1:0]    rc_metadata_q, rc_metadata_d;
    logic [DEST_WIDTH-1:0]    rc_dest_q, rc_dest_d;
    logic [INGRESS_SIZE-1:0]  rc_port_q, rc_port_d;
    logic                     proto_err_q, proto_err_d;

    logic [NUM_BUFFERS-1:0]   eligible, pending, granted, pipe_hit;
    logic                     issue;
    logic [INGRESS_SIZE-1:0]  sel;

    always_comb begin
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            eligible[i] = (state_q[i] == StIdle) && buf_head_valid_i[i];
            pending[i]  = (state_q[i] == StPending);
            granted[i]  = (state_q[i] == StGranted);
            pipe_hit[i] = pipe_valid_i && (pipe_ingress_port_i == INGRESS_SIZE'(i));
        end
    end

    // Scan upward from rr_ptr with wrap; first eligible port wins.
    always_comb begin
        int unsigned idx;
        int unsigned nxt;
        issue    = 1'b0;
        sel      = '0;
        idx      = 0;
        rr_ptr_d = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_BUFFERS; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= NUM_BUFFERS) idx = idx - NUM_BUFFERS;
            if (!issue && eligible[idx]) begin
                issue = 1'b1;
                sel   = INGRESS_SIZE'(idx);
            end
        end
        nxt = 32'(sel) + 1;
        if (issue) rr_ptr_d = (nxt >= NUM_BUFFERS) ? '0 : INGRESS_SIZE'(nxt);
    end

    always_comb begin
        rc_metadata_d = rc_metadata_q;
        rc_dest_d     = rc_dest_q;
        rc_port_d     = rc_port_q;
        if (issue) begin
            rc_metadata_d = buf_metadata_i[sel];
            rc_dest_d     = buf_dest_i[sel];
            rc_port_d     = sel;
        end
        // Out-of-range ports never hit, so they fall into the error term too.
        proto_err_d = proto_err_q
                    | (pipe_valid_i && !(|(pipe_hit & pending)))
                    | (|(buf_tail_sent_i & ~granted));
    end

    always_comb begin
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StIdle: begin
                    if (issue && (sel == INGRESS_SIZE'(i))) state_d[i] = StPending;
                end
                StPending: begin
                    if (pipe_hit[i]) begin
                        if (!pipe_failed_i) begin
                            state_d[i] = StGranted;
                        end else if (RETRY_DELAY == 0) begin
                            state_d[i] = StIdle;
                        end else begin
                            state_d[i] = StWait;
                            cnt_d[i]   = CntW'(RETRY_DELAY);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q[i] == CntW'(1)) begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CntW'(1);
                    end
                end
                StGranted: begin
                    if (buf_tail_sent_i[i]) state_d[i] = StIdle;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
            rr_ptr_q      <= '0;
            rc_valid_q    <= 1'b0;
            rc_metadata_q <= '0;
            rc_dest_q     <= '0;
            rc_port_q     <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            rr_ptr_q      <= rr_ptr_d;
            rc_valid_q    <= issue;
            rc_metadata_q <= rc_metadata_d;
            rc_dest_q     <= rc_dest_d;
            rc_port_q     <= rc_port_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign rc_valid_o        = rc_valid_q;
    assign rc_metadata_o     = rc_metadata_q;
    assign rc_dest_o         = rc_dest_q;
    assign rc_ingress_port_o = rc_port_q;
    assign granted_o         = granted;
    assign proto_err_o       = proto_err_q;

endmodule

// File: tb/tb_pipeline_issue.sv
// Scoreboard bench for pipeline_issue: a cycle-level port model predicts issues, grants and
// protocol errors; a monitor pops predicted issues whenever rc_valid is seen.
module tb_pipeline_issue;

    localparam int N  = 5;
    localparam int D  = 4;
    localparam int MW = 8;
    localparam int DW = 4;
    localparam int IW = 3;

    logic                   clk;
    logic                   rst;
    logic [N-1:0]           buf_head_valid;
    logic [N-1:0][MW-1:0]   buf_metadata;
    logic [N-1:0][DW-1:0]   buf_dest;
    logic [N-1:0]           buf_tail_sent;
    logic                   pipe_valid;
    logic [IW-1:0]          pipe_ingress_port;
    logic                   pipe_failed;
    logic                   rc_valid;
    logic [MW-1:0]          rc_metadata;
    logic [DW-1:0]          rc_dest;
    logic [IW-1:0]          rc_ingress_port;
    logic [N-1:0]           granted;
    logic                   proto_err;

    pipeline_issue #(
        .NUM_BUFFERS (N),
        .RETRY_DELAY (D),
        .META_WIDTH  (MW),
        .DEST_WIDTH  (DW)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .buf_head_valid_i    (buf_head_valid),
        .buf_metadata_i      (buf_metadata),
        .buf_dest_i          (buf_dest),
        .buf_tail_sent_i     (buf_tail_sent),
        .pipe_valid_i        (pipe_valid),
        .pipe_ingress_port_i (pipe_ingress_port),
        .pipe_failed_i       (pipe_failed),
        .rc_valid_o          (rc_valid),
        .rc_metadata_o       (rc_metadata),
        .rc_dest_o           (rc_dest),
        .rc_ingress_port_o   (rc_ingress_port),
        .granted_o           (granted),
        .proto_err_o         (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          port;
        logic [MW-1:0] meta;
        logic [DW-1:0] dest;
        int          at;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Model: a port is busy while pending or granted, and after a failure it may not be
    // selected before edge (failure edge + D + 1).
    bit m_pend     [N];
    bit m_gnt      [N];
    int m_earliest [N];
    int m_rr;
    bit m_err;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i]     = 1'b0;
            m_gnt[i]      = 1'b0;
            m_earliest[i] = 0;
        end
        m_rr  = 0;
        m_err = 1'b0;
    endtask

    // One clock: check state left by the previous edge, drive inputs, predict the next edge.
    task automatic step(input logic [N-1:0] hv, input bit pv, input int pport, input bit pf,
                        input logic [N-1:0] tail, input bit r);
        int           e;
        int           sel;
        int           idx;
        logic [N-1:0] gv;
        @(negedge clk);
        for (int i = 0; i < N; i++) gv[i] = m_gnt[i];
        chk("granted", granted, gv);
        chk("proto_err", proto_err, m_err);
        rst               = r;
        buf_head_valid    = hv;
        pipe_valid        = pv;
        pipe_ingress_port = IW'(pport);
        pipe_failed       = pf;
        buf_tail_sent     = tail;
        for (int i = 0; i < N; i++) begin
            buf_metadata[i] = MW'($urandom);
            buf_dest[i]     = DW'($urandom);
        end
        e = cyc + 1;
        if (r) begin
            model_reset();
            return;
        end
        sel = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (sel < 0 && hv[idx] && !m_pend[idx] && !m_gnt[idx] && e >= m_earliest[idx])
                sel = idx;
        end
        for (int i = 0; i < N; i++) begin
            if (tail[i]) begin
                if (m_gnt[i]) m_gnt[i] = 1'b0;
                else m_err = 1'b1;
            end
        end
        if (pv) begin
            if (pport < N && m_pend[pport]) begin
                m_pend[pport] = 1'b0;
                if (pf) m_earliest[pport] = e + D + 1;
                else m_gnt[pport] = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
        if (sel >= 0) begin
            m_pend[sel] = 1'b1;
            m_rr        = (sel + 1) % N;
            exp_q.push_back('{sel, buf_metadata[sel], buf_dest[sel], e});
        end
    endtask

    task automatic idle(input int n, input logic [N-1:0] hv);
        for (int i = 0; i < n; i++) step(hv, 1'b0, 0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step('0, 1'b0, 0, 1'b0, '0, 1'b1);
        step('0, 1'b0, 0, 1'b0, '0, 1'b0);
    endtask

    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rc_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue: got port %0d expected no issue (cycle %0d)",
                             rc_ingress_port, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue_cycle", cyc, mon_e.at);
                    chk("rc_ingress_port", rc_ingress_port, mon_e.port);
                    chk("rc_metadata", rc_metadata, mon_e.meta);
                    chk("rc_dest", rc_dest, mon_e.dest);
                end
            end else if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_issue: got no rc_valid expected port %0d (cycle %0d)",
                         mon_e.port, cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] hv;
        logic [N-1:0] tl;
        int           pl[$];
        int           pp;
        bit           pv;
        rst = 1'b1;
        buf_head_valid = '0; buf_metadata = '0; buf_dest = '0; buf_tail_sent = '0;
        pipe_valid = 1'b0; pipe_ingress_port = '0; pipe_failed = 1'b0;
        model_reset();

        // Reset values
        step('0, 1'b0, 0, 1'b0, '0, 1'b1);
        step('0, 1'b0, 0, 1'b0, '0, 1'b0);
        chk("reset_rc_valid", rc_valid, 0);
        chk("reset_rc_metadata", rc_metadata, 0);
        chk("reset_rc_dest", rc_dest, 0);
        chk("reset_rc_port", rc_ingress_port, 0);

        // Single request, grant, tail
        step(5'b00100, 1'b0, 0, 1'b0, '0, 1'b0);
        step('0, 1'b1, 2, 1'b0, '0, 1'b0);
        step('0, 1'b0, 0, 1'b0, 5'b00100, 1'b0);
        idle(2, '0);

        // Round-robin from a fresh pointer
        do_reset();
        idle(8, 5'b11111);

        // Retry backoff
        do_reset();
        step(5'b00010, 1'b0, 0, 1'b0, '0, 1'b0);
        step(5'b00010, 1'b1, 1, 1'b1, '0, 1'b0);
        idle(8, 5'b00010);
        step('0, 1'b1, 1, 1'b0, '0, 1'b0);
        idle(1, '0);

        // Simultaneous pipe success, tail and issue
        do_reset();
        step(5'b01000, 1'b0, 0, 1'b0, '0, 1'b0);
        step(5'b00001, 1'b1, 3, 1'b0, '0, 1'b0);
        step(5'b10000, 1'b1, 0, 1'b0, 5'b01000, 1'b0);
        idle(2, '0);

        // Protocol errors
        do_reset();
        step('0, 1'b1, 2, 1'b0, '0, 1'b0);
        step(5'b00010, 1'b0, 0, 1'b0, '0, 1'b0);
        step('0, 1'b0, 0, 1'b0, 5'b00010, 1'b0);
        step('0, 1'b1, 1, 1'b0, '0, 1'b0);
        step('0, 1'b1, 6, 1'b0, '0, 1'b0);
        idle(2, '0);

        // Reset mid-flight, then a late pipe result
        do_reset();
        step(5'b01000, 1'b0, 0, 1'b0, '0, 1'b0);
        step(5'b00001, 1'b1, 3, 1'b0, '0, 1'b0);
        step(5'b00100, 1'b0, 0, 1'b0, '0, 1'b0);
        step(5'b11111, 1'b0, 0, 1'b0, '0, 1'b1);
        step(5'b11111, 1'b0, 0, 1'b0, '0, 1'b0);
        step('0, 1'b1, 2, 1'b0, '0, 1'b0);
        idle(2, '0);

        // Random legal traffic, then random traffic with protocol violations and resets
        do_reset();
        for (int c = 0; c < 700; c++) begin
            hv = N'($urandom);
            pl.delete();
            for (int i = 0; i < N; i++) if (m_pend[i]) pl.push_back(i);
            pv = (pl.size() > 0) && ($urandom_range(0, 1) == 1);
            pp = pv ? pl[$urandom_range(0, pl.size() - 1)] : 0;
            tl = '0;
            for (int i = 0; i < N; i++) if (m_gnt[i] && $urandom_range(0, 2) == 0) tl[i] = 1'b1;
            if (c >= 450) begin
                if ($urandom_range(0, 9) == 0) begin
                    pv = 1'b1;
                    pp = $urandom_range(0, 7);
                end
                if ($urandom_range(0, 14) == 0) tl[$urandom_range(0, N - 1)] = 1'b1;
            end
            step(hv, pv, pp, $urandom_range(0, 2) == 0, tl,
                 c >= 450 && $urandom_range(0, 59) == 0);
        end

        idle(4, '0);
        chk("issues_outstanding", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
